floo_axis_flit_demux: RTL and testbench
=======================================

// Module: floo_axis_flit_demux
// PURPOSE
// - Receive-side endpoint of the AXIS serial-link channel. Takes AXIS beats whose tdata is {hdr, flit_data}
//   and splits them back into NoC req and rsp flit streams (hdr 0 = req, hdr 1 = rsp).
// - One buffer per class, so a stalled class does not block the other once its beat has been accepted.
// - Emits one credit pulse per class per flit drained, for flow control on the transmit side of the link.
// - Sits between the link-layer AXIS output and the local NoC router ports.
// PARAMETERS
// - FlitDataWidth  64     width of flit_data; tdata width = FlitDataWidth+1
// - FifoDepth      4      entries per class buffer; >=2, power of two
// - CntWidth       16     width of per-class accepted-flit statistics counters
// PORTS
// - clk_i              in   1                clock
// - rst_i              in   1                synchronous reset, active-high
// - axis_tvalid_i      in   1                AXIS beat valid
// - axis_tready_o      out  1                AXIS beat ready
// - axis_tdata_i       in   FlitDataWidth+1  [FlitDataWidth] = hdr, [FlitDataWidth-1:0] = flit_data
// - req_valid_o        out  1                req flit valid toward NoC
// - req_ready_i        in   1                req flit accepted by NoC
// - req_data_o         out  FlitDataWidth    req flit payload
// - rsp_valid_o        out  1                rsp flit valid toward NoC
// - rsp_ready_i        in   1                rsp flit accepted by NoC
// - rsp_data_o         out  FlitDataWidth    rsp flit payload
// - credit_req_o       out  1                1-cycle pulse per req flit handed to NoC
// - credit_rsp_o       out  1                1-cycle pulse per rsp flit handed to NoC
// - req_cnt_o          out  CntWidth         req flits accepted from AXIS since reset, wraps
// - rsp_cnt_o          out  CntWidth         rsp flits accepted from AXIS since reset, wraps
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): both buffers empty; all valids, credit pulses, counters = 0; axis_tready_o = 0 while rst_i is high.
// - Beat routing: hdr selects the target class. axis_tready_o = !full(target class). Registered state only, no combinational path from req_ready_i/rsp_ready_i.
// - Push: on tvalid&&tready, flit_data is written to the target class buffer and that class counter increments, wrapping at 2^CntWidth.
// - Latency: beat accepted at edge N -> flit visible on *_valid_o/*_data_o after edge N (cycle N+1), no fall-through.
// - Pop: *_valid_o = !empty; on valid&&ready the head leaves the buffer and credit_*_o is high for exactly the following cycle (registered).
// - AXIS hold: tvalid high with tready low keeps the beat pending; the transmitter holds tdata stable.
// - Full buffer: a pop on a full buffer does not raise tready in the same cycle. tready rises the cycle after the pop.
// - Simultaneous push and pop on the same non-full buffer: both occur, occupancy unchanged, order preserved.
// - Both classes drain independently in the same cycle. Two credit pulses may coincide.
// - Order within each class is FIFO. No ordering between classes.
// - Reset mid-operation: buffered flits are discarded and no credit pulse is issued for them.
//   The credit-tracking side is reset in the same domain.
// - Assertions (simulation): *_valid_o held && !*_ready_i -> *_data_o stable next cycle; no push when full.
// STRUCTURE
// - Shared package floo_axis_link_pkg:
//   - axis_payload_t packed {hdr, flit_data}
//   - localparam HdrReq = 1'b0, HdrRsp = 1'b1
//   - credit pulse typedef shared with the transmit-side credit counter
// - Sub-module floo_axis_class_fifo, instantiated twice (req, rsp):
//   - sync active-high reset, depth FifoDepth
//   - registered full/empty
//   - generates the credit pulse on pop
// - Top level: hdr decode, tready mux, statistics counters, assertions.
// TESTING
// - Single beat {hdr=0, data=0xA5} -> req_valid_o at next cycle with data 0xA5; credit_req_o pulses one cycle after req handshake; req_cnt_o=1.
// - Alternate hdr 0/1 for 8 beats, both readies held 1 -> every beat accepted back-to-back; 4 req and 4 rsp flits out in order; 4+4 credits.
// - rsp_ready_i=0, send 4 rsp beats then 1 req beat -> 5th beat accepted (req path free); a 5th rsp beat -> tready=0 until the cycle after the first rsp pop.
// - Full req buffer with pop and a pending req beat in the same cycle -> pop occurs; beat accepted only the following cycle; no data lost.
// - Counter wrap with CntWidth=4: 17 req beats -> req_cnt_o=1.
// - rst_i asserted with 3 buffered flits -> next cycle valids=0, counters=0, no credit pulse; traffic after reset is delivered normally.

Source files
------------

// File: rtl/floo_axis_link_pkg.sv
// Shared definitions for the AXIS serial-link endpoints.
// - HdrReq / HdrRsp: header bit values that select the NoC class of a beat.
// - axis_payload_t: layout of an AXIS beat, {hdr, flit_data}, at the default flit width.
// - credit_pulse_t: one-cycle credit return pulse, shared with the transmit-side credit counter.
package floo_axis_link_pkg;

  localparam int unsigned DefFlitDataWidth = 64;

  localparam logic HdrReq = 1'b0;
  localparam logic HdrRsp = 1'b1;

  typedef struct packed {
    logic                        hdr;
    logic [DefFlitDataWidth-1:0] flit_data;
  } axis_payload_t;

  typedef logic credit_pulse_t;

endpackage

// File: rtl/floo_axis_class_fifo.sv
// Per-class flit buffer with registered full/empty and a credit pulse per drained flit.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, data_i    write strobe and payload (ignored while full)
//   full_o            registered full flag
//   valid_o, ready_i  head-of-queue handshake toward the NoC
//   data_o            head-of-queue payload
//   credit_o          high for the one cycle after each pop
module floo_axis_class_fifo
  import floo_axis_link_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 full_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output credit_pulse_t        credit_o
);

  localparam int unsigned AddrWidth = $clog2(Depth);
  localparam int unsigned CntW      = AddrWidth + 1;

  logic [DataWidth-1:0] mem [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 full_q, empty_q;
  credit_pulse_t        credit_q;
  logic                 push, pop;

  assign pop  = !empty_q && ready_i;
  assign push = push_i && !full_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      credit_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
      count_q  <= count_d;
      // Flags are registered from the next count: a pop on a full buffer
      // only frees a slot for the beat presented in the following cycle.
      full_q   <= (count_d == CntW'(Depth));
      empty_q  <= (count_d == '0);
      credit_q <= pop;
    end
  end

  // NOTE: storage is not reset; the pointers and count already mark every entry invalid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= data_i;
  end

  assign full_o   = full_q;
  assign valid_o  = !empty_q;
  assign data_o   = mem[rd_ptr_q];
  assign credit_o = credit_q;

endmodule

// File: rtl/floo_axis_flit_demux.sv
// Receive-side AXIS link endpoint: splits {hdr, flit_data} beats into NoC req/rsp flit streams.
// Ports:
//   clk_i, rst_i                               clock, synchronous active-high reset
//   axis_tvalid_i, axis_tready_o, axis_tdata_i AXIS input, tdata = {hdr, flit_data}
//   req_valid_o, req_ready_i, req_data_o       req flit stream toward the NoC (hdr 0)
//   rsp_valid_o, rsp_ready_i, rsp_data_o       rsp flit stream toward the NoC (hdr 1)
//   credit_req_o, credit_rsp_o                 one pulse per flit handed to the NoC
//   req_cnt_o, rsp_cnt_o                       wrapping counts of flits accepted from AXIS
module floo_axis_flit_demux
  import floo_axis_link_pkg::*;
#(
  parameter int unsigned FlitDataWidth = DefFlitDataWidth,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     axis_tvalid_i,
  output logic                     axis_tready_o,
  input  logic [FlitDataWidth:0]   axis_tdata_i,
  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  output logic [FlitDataWidth-1:0] req_data_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [FlitDataWidth-1:0] rsp_data_o,
  output logic                     credit_req_o,
  output logic                     credit_rsp_o,
  output logic [CntWidth-1:0]      req_cnt_o,
  output logic [CntWidth-1:0]      rsp_cnt_o
);

  logic                     hdr;
  logic [FlitDataWidth-1:0] flit_data;
  logic                     req_full, rsp_full, target_full;
  logic                     accept, push_req, push_rsp;
  logic [CntWidth-1:0]      req_cnt_q, rsp_cnt_q;
  credit_pulse_t            credit_req, credit_rsp;

  assign hdr       = axis_tdata_i[FlitDataWidth];
  assign flit_data = axis_tdata_i[FlitDataWidth-1:0];

  // tready depends only on registered full flags of the addressed class,
  // so a NoC ready never reaches the link side combinationally.
  assign target_full   = (hdr == HdrRsp) ? rsp_full : req_full;
  assign axis_tready_o = !rst_i && !target_full;

  assign accept   = axis_tvalid_i && axis_tready_o;
  assign push_req = accept && (hdr == HdrReq);
  assign push_rsp = accept && (hdr == HdrRsp);

  floo_axis_class_fifo #(
    .DataWidth (FlitDataWidth),
    .Depth     (FifoDepth)
  ) i_req_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push_req),
    .data_i   (flit_data),
    .full_o   (req_full),
    .valid_o  (req_valid_o),
    .ready_i  (req_ready_i),
    .data_o   (req_data_o),
    .credit_o (credit_req)
  );

  floo_axis_class_fifo #(
    .DataWidth (FlitDataWidth),
    .Depth     (FifoDepth)
  ) i_rsp_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push_rsp),
    .data_i   (flit_data),
    .full_o   (rsp_full),
    .valid_o  (rsp_valid_o),
    .ready_i  (rsp_ready_i),
    .data_o   (rsp_data_o),
    .credit_o (credit_rsp)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (push_req) req_cnt_q <= req_cnt_q + CntWidth'(1);
      if (push_rsp) rsp_cnt_q <= rsp_cnt_q + CntWidth'(1);
    end
  end

  assign req_cnt_o    = req_cnt_q;
  assign rsp_cnt_o    = rsp_cnt_q;
  assign credit_req_o = credit_req;
  assign credit_rsp_o = credit_rsp;

  a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (req_valid_o && !req_ready_i) |=> $stable(req_data_o));
  a_rsp_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (rsp_valid_o && !rsp_ready_i) |=> $stable(rsp_data_o));
  a_req_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
    push_req |-> !req_full);
  a_rsp_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
    push_rsp |-> !rsp_full);

endmodule

// File: tb/tb_floo_axis_flit_demux.sv
// Directed self-checking bench for floo_axis_flit_demux (FifoDepth=4, CntWidth=4).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_floo_axis_flit_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid;
  logic        tready;
  logic [64:0] tdata;
  logic        req_valid, req_ready;
  logic [63:0] req_data;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic        credit_req, credit_rsp;
  logic [3:0]  req_cnt, rsp_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  floo_axis_flit_demux #(
    .FlitDataWidth (64),
    .FifoDepth     (4),
    .CntWidth      (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .axis_tvalid_i (tvalid),
    .axis_tready_o (tready),
    .axis_tdata_i  (tdata),
    .req_valid_o   (req_valid),
    .req_ready_i   (req_ready),
    .req_data_o    (req_data),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .credit_req_o  (credit_req),
    .credit_rsp_o  (credit_rsp),
    .req_cnt_o     (req_cnt),
    .rsp_cnt_o     (rsp_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hdr, input logic [63:0] data);
    tvalid = 1'b1;
    tdata  = {hdr, data};
  endtask

  initial begin
    rst = 1'b1; tvalid = 1'b0; tdata = '0; req_ready = 1'b0; rsp_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_tready",    64'(tready),     64'd0);
    check("rst_req_valid", 64'(req_valid),  64'd0);
    check("rst_rsp_valid", 64'(rsp_valid),  64'd0);
    check("rst_credit_rq", 64'(credit_req), 64'd0);
    check("rst_credit_rs", 64'(credit_rsp), 64'd0);
    check("rst_req_cnt",   64'(req_cnt),    64'd0);
    check("rst_rsp_cnt",   64'(rsp_cnt),    64'd0);
    rst = 1'b0;

    // Single req beat 0xA5
    drive(1'b0, 64'hA5);
    #1 check("single_tready", 64'(tready), 64'd1);
    tick();
    tvalid = 1'b0;
    check("single_valid",  64'(req_valid),  64'd1);
    check("single_data",   req_data,        64'hA5);
    check("single_cnt",    64'(req_cnt),    64'd1);
    check("single_nocred", 64'(credit_req), 64'd0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("single_credit", 64'(credit_req), 64'd1);
    check("single_empty",  64'(req_valid),  64'd0);
    tick();
    check("single_cred_1cyc", 64'(credit_req), 64'd0);

    // Alternating req/rsp beats, both readies high: one beat per cycle
    req_ready = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'(i % 2), 64'h100 + 64'(i));
      #1 check("alt_tready", 64'(tready), 64'd1);
      tick();
      if (i % 2 == 0) begin
        check("alt_req_valid", 64'(req_valid), 64'd1);
        check("alt_req_data",  req_data, 64'h100 + 64'(i));
        check("alt_rsp_idle",  64'(rsp_valid), 64'd0);
        check("alt_req_cred0", 64'(credit_req), 64'd0);
        if (i > 0) check("alt_rsp_cred", 64'(credit_rsp), 64'd1);
      end else begin
        check("alt_rsp_valid", 64'(rsp_valid), 64'd1);
        check("alt_rsp_data",  rsp_data, 64'h100 + 64'(i));
        check("alt_req_idle",  64'(req_valid), 64'd0);
        check("alt_req_cred",  64'(credit_req), 64'd1);
        check("alt_rsp_cred0", 64'(credit_rsp), 64'd0);
      end
    end
    tvalid = 1'b0;
    tick();
    check("alt_last_cred", 64'(credit_rsp), 64'd1);
    check("alt_rsp_drain", 64'(rsp_valid),  64'd0);
    check("alt_req_drain", 64'(req_valid),  64'd0);
    check("alt_req_cnt",   64'(req_cnt),    64'd5);
    check("alt_rsp_cnt",   64'(rsp_cnt),    64'd4);
    req_ready = 1'b0; rsp_ready = 1'b0;

    // Fill rsp buffer; req beat still passes; 5th rsp beat stalls until after a pop
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 64'h200 + 64'(j));
      #1 check("fill_rsp_tready", 64'(tready), 64'd1);
      tick();
    end
    drive(1'b0, 64'h300);
    #1 check("req_free_tready", 64'(tready), 64'd1);
    tick();
    check("req_free_valid", 64'(req_valid), 64'd1);
    check("req_free_data",  req_data, 64'h300);
    drive(1'b1, 64'h204);
    #1 check("rsp_full_tready", 64'(tready), 64'd0);
    tick();
    check("rsp_full_hold", 64'(tready), 64'd0);
    rsp_ready = 1'b1;
    #1 check("rsp_pop_no_comb", 64'(tready), 64'd0);
    tick();
    rsp_ready = 1'b0;
    check("rsp_pop_credit", 64'(credit_rsp), 64'd1);
    check("rsp_pop_head",   rsp_data, 64'h201);
    check("rsp_after_pop_tready", 64'(tready), 64'd1);
    tick();
    tvalid = 1'b0;
    check("rsp_cnt_9", 64'(rsp_cnt), 64'd9);
    check("req_cnt_6", 64'(req_cnt), 64'd6);
    rsp_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      check("rsp_drain_valid", 64'(rsp_valid), 64'd1);
      check("rsp_drain_data",  rsp_data, 64'h200 + 64'(j));
      tick();
    end
    check("rsp_drained", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b0;

    // Full req buffer: pop and pending beat in the same cycle
    for (int j = 1; j <= 3; j++) begin
      drive(1'b0, 64'h300 + 64'(j));
      #1 check("fill_req_tready", 64'(tready), 64'd1);
      tick();
    end
    check("req_cnt_9", 64'(req_cnt), 64'd9);
    drive(1'b0, 64'h304);
    req_ready = 1'b1;
    #1 check("req_full_pop_tready", 64'(tready), 64'd0);
    tick();
    req_ready = 1'b0;
    check("req_full_credit",  64'(credit_req), 64'd1);
    check("req_full_head",    req_data, 64'h301);
    check("req_full_tready1", 64'(tready), 64'd1);
    check("req_full_not_yet", 64'(req_cnt), 64'd9);
    tick();
    tvalid = 1'b0;
    check("req_cnt_10", 64'(req_cnt), 64'd10);
    req_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      check("req_drain_valid", 64'(req_valid), 64'd1);
      check("req_drain_data",  req_data, 64'h300 + 64'(j));
      tick();
    end
    check("req_drained", 64'(req_valid), 64'd0);
    req_ready = 1'b0;

    // Reset with 3 buffered flits, a req pop requested at the reset edge
    drive(1'b0, 64'h400); tick();
    drive(1'b0, 64'h401); tick();
    drive(1'b1, 64'h500); tick();
    tvalid = 1'b0;
    check("pre_rst_req_valid", 64'(req_valid), 64'd1);
    check("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    req_ready = 1'b1;
    tick();
    check("mid_rst_req_valid", 64'(req_valid),  64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid),  64'd0);
    check("mid_rst_req_cnt",   64'(req_cnt),    64'd0);
    check("mid_rst_rsp_cnt",   64'(rsp_cnt),    64'd0);
    check("mid_rst_credit_rq", 64'(credit_req), 64'd0);
    check("mid_rst_credit_rs", 64'(credit_rsp), 64'd0);
    check("mid_rst_tready",    64'(tready),     64'd0);
    rst = 1'b0;
    req_ready = 1'b0;
    tick();
    check("post_rst_credit", 64'(credit_req), 64'd0);
    check("post_rst_valid",  64'(req_valid),  64'd0);

    // 17 req beats after reset: counter wraps to 1
    req_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 64'h600 + 64'(i));
      #1 check("wrap_tready", 64'(tready), 64'd1);
      tick();
      check("wrap_valid", 64'(req_valid), 64'd1);
      check("wrap_data",  req_data, 64'h600 + 64'(i));
    end
    tvalid = 1'b0;
    check("wrap_req_cnt", 64'(req_cnt), 64'd1);
    check("wrap_rsp_cnt", 64'(rsp_cnt), 64'd0);
    tick();
    check("wrap_drained", 64'(req_valid), 64'd0);
    req_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
